// File: rtl/spi_max7219_receiver_if.sv
// spi_max7219_receiver_if
//   Groups the SPI pins and the decoded-word outputs of the MAX7219 frame
//   receiver.
//   master : drives cs_n/sck/mosi and observes the decoded word (test driver
//            or the display-link transmitter side).
//   slave  : the receiver. It samples cs_n/sck/mosi and drives word_valid,
//            word_addr, word_data and frame_err.
//
//   cs_n       SPI chip select, active low (asynchronous to clk)
//   sck        SPI serial clock, idle low (asynchronous to clk)
//   mosi       SPI data, sampled on sck rising edge, MSB first
//   word_valid one-cycle pulse per committed 16-bit frame
//   word_addr  address nibble of the last good frame
//   word_data  data byte of the last good frame
//   frame_err  one-cycle pulse per frame whose bit count was not 16
interface spi_max7219_receiver_if;
    logic       cs_n;
    logic       sck;
    logic       mosi;
    logic       word_valid;
    logic [3:0] word_addr;
    logic [7:0] word_data;
    logic       frame_err;

    modport master (
        output cs_n, sck, mosi,
        input  word_valid, word_addr, word_data, frame_err
    );

    modport slave (
        input  cs_n, sck, mosi,
        output word_valid, word_addr, word_data, frame_err
    );
endinterface

// File: rtl/spi_max7219_receiver.sv
// spi_max7219_receiver
//   Oversampled SPI slave that decodes MAX7219-style 16-bit frames and keeps a
//   shadow copy of the display controller registers. Nothing is clocked by
//   sck; the three SPI pins are synchronized to clk and edges are detected.
//
//   Parameters
//     SYNC_STAGES  synchronizer depth on cs_n/sck/mosi (must be >= 2)
//     ERR_CNT_W    width of the saturating frame-error counter
//
//   Ports
//     clk          system clock
//     res          synchronous reset, active low
//     bus          SPI pins in, decoded word / frame_err out (slave modport)
//     err_cnt      saturating count of frame_err pulses
//     frame_cnt    count of good frames, wraps
//     rd_addr      digit read select (0 -> digit 1 ... 7 -> digit 8)
//     rd_data      combinational read of the selected digit register
//     decode_mode  register 0x9
//     intensity    register 0xA[3:0]
//     scan_limit   register 0xB[2:0]
//     shutdown_n   register 0xC[0], 1 = normal operation
//     display_test register 0xF[0]
module spi_max7219_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      res,
    spi_max7219_receiver_if.slave     bus,
    output logic [ERR_CNT_W-1:0]      err_cnt,
    output logic [15:0]               frame_cnt,
    input  logic [2:0]                rd_addr,
    output logic [7:0]                rd_data,
    output logic [7:0]                decode_mode,
    output logic [3:0]                intensity,
    output logic [2:0]                scan_limit,
    output logic                      shutdown_n,
    output logic                      display_test
);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

    localparam logic [4:0] BIT_SAT = 5'd17;

    // ------------------------------------------------------------------
    // Synchronizers. All three pins get identical depth so the mosi bit
    // seen at the synchronized sck rising edge is the bit that was on the
    // pin when sck rose.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_hist;
    logic                   sck_hist;

    always_ff @(posedge clk) begin
        if (!res) begin
            cs_sync   <= '0;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_hist   <= 1'b0;
            sck_hist  <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   bus.cs_n};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0],  bus.sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            cs_hist   <= cs_sync[SYNC_STAGES-1];
            sck_hist  <= sck_sync[SYNC_STAGES-1];
        end
    end

    logic cs_s, sck_s, mosi_s;
    logic cs_rise, cs_fall, sck_rise;

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_rise  =  cs_s & ~cs_hist;
    assign cs_fall  = ~cs_s &  cs_hist;
    assign sck_rise =  sck_s & ~sck_hist;

    // ------------------------------------------------------------------
    // Frame FSM, counters and register file
    // ------------------------------------------------------------------
    state_t      state;
    logic [4:0]  bit_cnt;
    logic [15:0] shift_reg;
    logic [7:0]  digit_reg [8];

    logic [3:0]  frm_addr;
    logic [7:0]  frm_data;
    logic [2:0]  digit_sel;
    logic [3:0]  unused_hi_nibble;

    assign frm_addr = shift_reg[11:8];
    assign frm_data = shift_reg[7:0];
    // Addresses 1..8 map to digit 0..7; the low three address bits minus one
    // give that mapping directly (8 = 3'b000 wraps to 7).
    assign digit_sel = shift_reg[10:8] - 3'd1;
    // Frame bits 15:12 carry no meaning for the controller.
    assign unused_hi_nibble = shift_reg[15:12];

    always_ff @(posedge clk) begin
        if (!res) begin
            state          <= WAIT_IDLE;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            bus.word_valid <= 1'b0;
            bus.word_addr  <= '0;
            bus.word_data  <= '0;
            bus.frame_err  <= 1'b0;
            err_cnt        <= '0;
            frame_cnt      <= '0;
            decode_mode    <= '0;
            intensity      <= '0;
            scan_limit     <= '0;
            shutdown_n     <= 1'b0;
            display_test   <= 1'b0;
            for (int i = 0; i < 8; i++) digit_reg[i] <= '0;
        end else begin
            bus.word_valid <= 1'b0;
            bus.frame_err  <= 1'b0;

            case (state)
                // Coming out of reset cs_n may already be low mid-frame;
                // wait for the bus to go idle so that frame is never taken.
                WAIT_IDLE: begin
                    if (cs_s) state <= IDLE;
                end

                IDLE: begin
                    if (cs_fall) begin
                        state     <= SHIFT;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end

                SHIFT: begin
                    // End of frame takes priority over a coincident sck edge.
                    if (cs_rise) begin
                        state <= IDLE;
                        if (bit_cnt == 5'd16) begin
                            bus.word_valid <= 1'b1;
                            bus.word_addr  <= frm_addr;
                            bus.word_data  <= frm_data;
                            frame_cnt      <= frame_cnt + 16'd1;
                            case (frm_addr)
                                4'h1, 4'h2, 4'h3, 4'h4,
                                4'h5, 4'h6, 4'h7, 4'h8: digit_reg[digit_sel] <= frm_data;
                                4'h9: decode_mode  <= frm_data;
                                4'hA: intensity    <= frm_data[3:0];
                                4'hB: scan_limit   <= frm_data[2:0];
                                4'hC: shutdown_n   <= frm_data[0];
                                4'hF: display_test <= frm_data[0];
                                default: ; // 0x0 no-op, 0xD/0xE unmapped
                            endcase
                        end else begin
                            bus.frame_err <= 1'b1;
                            if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
                        end
                    end else if (sck_rise) begin
                        shift_reg <= {shift_reg[14:0], mosi_s};
                        // Saturating at 17 keeps "too long" distinct from 16.
                        if (bit_cnt != BIT_SAT) bit_cnt <= bit_cnt + 5'd1;
                    end
                end

                default: state <= WAIT_IDLE;
            endcase
        end
    end

    // Register-file write lands at the clock edge, so a same-cycle read
    // still returns the old digit value.
    assign rd_data = digit_reg[rd_addr];

endmodule

// File: doc/spi_max7219_receiver.md
Name: spi_max7219_receiver

Overview:
- Synchronous SPI slave that decodes MAX7219-style 16-bit frames (CS low, SCK idle low, MOSI sampled on SCK rising edge, MSB first).
- Keeps a shadow copy of the display controller's register set: digits 1-8, decode mode, intensity, scan limit, shutdown and display test.
- Sits on the receive side of the stopwatch display link, either as an on-chip loopback monitor or as a display-side decoder.
- All SPI pins are oversampled by the system clock; no logic is clocked by SCK.

Parameters:
- SYNC_STAGES, 2: synchronizer depth on cs_n, sck and mosi (minimum 2).
- ERR_CNT_W, 8: width of the saturating frame-error counter.

Ports:
- clk  input  1  system clock (1 MHz nominal).
- res  input  1  synchronous reset, active low.
- cs_n  input  1  SPI chip select, active low, asynchronous to clk.
- sck  input  1  SPI serial clock, asynchronous to clk.
- mosi  input  1  SPI data in, asynchronous to clk.
- word_valid  output  1  one-cycle pulse when a well-formed 16-bit frame is committed.
- word_addr  output  4  address nibble (bits 11:8) of the last good frame.
- word_data  output  8  data byte (bits 7:0) of the last good frame.
- frame_err  output  1  one-cycle pulse when a frame ends with a bit count other than 16.
- err_cnt  output  ERR_CNT_W  saturating count of frame_err pulses.
- frame_cnt  output  16  count of good frames, wraps modulo 2^16.
- rd_addr  input  3  digit read select; 0 selects digit register 1, 7 selects digit register 8.
- rd_data  output  8  combinational read of the selected digit register.
- decode_mode  output  8  register 0x9.
- intensity  output  4  register 0xA, bits 3:0.
- scan_limit  output  3  register 0xB, bits 2:0.
- shutdown_n  output  1  register 0xC, bit 0 (1 = normal operation).
- display_test  output  1  register 0xF, bit 0.

Behaviour:
- Reset (res low at a clk edge):
  - All outputs, digit registers, counters and synchronizers clear to 0; this includes shutdown_n = 0.
  - The FSM enters WAIT_IDLE, the bit counter clears, and any partially received frame is discarded.
- Synchronization:
  - cs_n, sck and mosi each pass through SYNC_STAGES flops, plus one history flop used for edge detection.
  - All three signals share equal delay, so mosi stays aligned to the sck edge.
- SPI timing requirement: SCK high and low phases are each at least 2 clk cycles. Faster SCK is out of scope and behaviour is undefined.
- FSM states:
  - WAIT_IDLE: waits for synchronized cs_n = 1, then goes to IDLE. This prevents capturing a frame that started before reset was released.
  - IDLE: SCK edges are ignored. A falling edge of synchronized cs_n goes to SHIFT and clears the bit counter and shift register.
  - SHIFT:
    - Each synchronized SCK rising edge shifts mosi into a 16-bit shift register (left shift, LSB in).
    - The bit counter increments and saturates at 17.
    - A synchronized cs_n rising edge ends the frame and returns to IDLE.
- End of frame:
  - Bit count exactly 16: commit the frame.
    - word_valid pulses; word_addr and word_data update; frame_cnt increments.
    - The register file is updated.
  - Any other count, including 0 and more than 16: no commit.
    - frame_err pulses; err_cnt increments, saturating at all-ones.
    - word_addr, word_data and the register file are unchanged.
- Simultaneous events: if a cs_n rising edge and an sck rising edge are detected in the same cycle, the cs_n edge wins and the sck edge is ignored.
- Latency: cs_n rising at the pin, sampled at clk edge k, gives word_valid or frame_err high for exactly the one cycle after edge k+SYNC_STAGES. With the default of 2, that is the cycle after edge k+2.
- Address decode:
  - Frame bits 15:12 are ignored.
  - 0x0: no-op; word_valid still pulses, no register changes.
  - 0x1-0x8: write digit register (address - 1).
  - 0x9: decode_mode.
  - 0xA: intensity (bits 3:0 taken).
  - 0xB: scan_limit (bits 2:0 taken).
  - 0xC: shutdown_n (bit 0 taken).
  - 0xF: display_test (bit 0 taken).
  - 0xD and 0xE: no register write, but word_valid pulses and frame_cnt increments.
- Register file outputs update in the same cycle that word_valid is high.
- rd_data is combinational from rd_addr. A write and a read to the same digit in the same cycle returns the old value.

Test Plan:
- Send frame 0x0C01 -> word_valid one cycle, word_addr = 0xC, word_data = 0x01, shutdown_n = 1, frame_cnt = 1, err_cnt = 0.
- Send 0x0385, then set rd_addr = 2 -> rd_data = 0x85. Send 0xF901 -> decode_mode = 0x01 (upper nibble ignored).
- Send 15 bits, then 17 bits, each closed by cs_n rising -> frame_err pulses twice, err_cnt = 2, word_addr, word_data and registers unchanged, no word_valid.
- Start frame 0x0A0F, assert res low for 3 cycles after bit 8, release with cs_n still low, finish the frame, then send 0x0A0F cleanly -> first frame ignored (no word_valid, no frame_err), second gives intensity = 0xF, frame_cnt = 1.
- Drive frame 0x0000 then 0x0D55 -> two word_valid pulses, frame_cnt = 2, no register changes. Then force the cs_n rising edge and the 16th sck rising edge into the same detection cycle -> frame_err, since the count is 15.
- Drive 300 frames of 1 bit each -> err_cnt saturates at 255. Then send 0x0801 -> digit register 8 = 0x01 via rd_addr = 7.
